// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch-stage PC sequencer: state encoding
// and default sequencing constants.
package mips_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RUN       = 3'd1;
    localparam logic [2:0] ST_STEP_WAIT = 3'd2;
    localparam logic [2:0] ST_STEP_EXEC = 3'd3;
    localparam logic [2:0] ST_DRAIN     = 3'd4;
    localparam logic [2:0] ST_HALTED    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_RUN       = ST_RUN,
        S_STEP_WAIT = ST_STEP_WAIT,
        S_STEP_EXEC = ST_STEP_EXEC,
        S_DRAIN     = ST_DRAIN,
        S_HALTED    = ST_HALTED
    } seq_state_e;

    localparam int PC_INC_DEF       = 4;
    localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/pc_sequencer_step_edge_detect.sv
// Turns the debug unit's level step request into a one-cycle pulse on its
// rising edge, so a held-high request yields a single step.
module step_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_step,
    output logic o_pulse
);

    logic step_q;

    always_ff @(negedge i_clk) begin
        if (!i_rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= i_step;
        end
    end

    assign o_pulse = i_step & ~step_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: run/step/halt sequencing, pipeline
// drain after HALT, redirect/stall PC selection and an executed-cycle counter.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int LEN          = 32,
    parameter int PC_INC       = PC_INC_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_LEN      = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_mode,
    input  logic               i_step,
    input  logic [LEN-1:0]     i_pc,
    input  logic               i_jump,
    input  logic [LEN-1:0]     i_jump_target,
    input  logic               i_branch_taken,
    input  logic [LEN-1:0]     i_branch_target,
    input  logic               i_stall,
    input  logic               i_halt_instr,
    output logic [LEN-1:0]     o_next_pc,
    output logic               o_run,
    output logic               o_flush,
    output logic               o_halted,
    output logic [CNT_LEN-1:0] o_cycles
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_e         state_q;
    logic [DCW-1:0]     drain_q;
    logic [CNT_LEN-1:0] cycles_q;
    logic               step_pulse;

    step_edge_detect u_step_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_step  (i_step),
        .o_pulse (step_pulse)
    );

    // Outputs are forced quiet while reset is held, independent of the state register.
    assign o_run    = i_rst & ((state_q == S_RUN) | (state_q == S_STEP_EXEC) |
                               (state_q == S_DRAIN));
    assign o_halted = i_rst & (state_q == S_HALTED);
    assign o_cycles = cycles_q;

    always_ff @(negedge i_clk) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            drain_q  <= '0;
            cycles_q <= '0;
        end else begin
            if (o_run && (cycles_q != '1)) begin
                cycles_q <= cycles_q + CNT_LEN'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= i_mode ? S_STEP_WAIT : S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_halt_instr) begin
                        state_q <= S_DRAIN;
                        drain_q <= DCW'(DRAIN_CYCLES - 1);
                    end
                end
                S_STEP_WAIT: begin
                    if (step_pulse) begin
                        state_q <= S_STEP_EXEC;
                    end
                end
                S_STEP_EXEC: begin
                    if (i_halt_instr) begin
                        state_q <= S_DRAIN;
                        drain_q <= DCW'(DRAIN_CYCLES - 1);
                    end else begin
                        state_q <= S_STEP_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= S_HALTED;
                    end else begin
                        drain_q <= drain_q - DCW'(1);
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Branch resolves in EX and is older than a jump decoded in ID, so it wins.
    always_comb begin
        o_next_pc = i_pc;
        o_flush   = 1'b0;
        if (!i_rst) begin
            o_next_pc = '0;
        end else if (o_run) begin
            if (i_branch_taken) begin
                o_next_pc = i_branch_target;
                o_flush   = 1'b1;
            end else if (i_jump) begin
                o_next_pc = i_jump_target;
                o_flush   = 1'b1;
            end else if (i_stall) begin
                o_next_pc = i_pc;
            end else begin
                o_next_pc = i_pc + LEN'(PC_INC);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed table, multi-cycle corner sequences and a
// randomized run against a behavioural model; a CNT_LEN=4 copy checks saturation.
module tb_pc_sequencer;

    logic        clk;
    logic        rst, start, mode, step, jump, branch, stall, halt;
    logic [31:0] pc, jt, bt;
    logic [31:0] next_pc, cycles;
    logic        run, flush, halted;
    logic [31:0] s_next_pc;
    logic        s_run, s_flush, s_halted;
    logic [3:0]  s_cycles;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst, start, mode, step, jump, branch, stall, halt;
        logic [31:0] pc, jt, bt;
        logic [31:0] e_next;
        logic        e_run, e_flush, e_halted;
        logic [31:0] e_cycles;
    } vec_t;

    pc_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_step(step),
        .i_pc(pc), .i_jump(jump), .i_jump_target(jt), .i_branch_taken(branch),
        .i_branch_target(bt), .i_stall(stall), .i_halt_instr(halt),
        .o_next_pc(next_pc), .o_run(run), .o_flush(flush), .o_halted(halted),
        .o_cycles(cycles)
    );

    pc_sequencer #(.CNT_LEN(4)) dut_small (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_step(step),
        .i_pc(pc), .i_jump(jump), .i_jump_target(jt), .i_branch_taken(branch),
        .i_branch_target(bt), .i_stall(stall), .i_halt_instr(halt),
        .o_next_pc(s_next_pc), .o_run(s_run), .o_flush(s_flush), .o_halted(s_halted),
        .o_cycles(s_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: phase of execution, remaining drain cycles, run count.
    localparam int P_IDLE = 0, P_CONT = 1, P_WAIT = 2, P_EXEC = 3, P_DRAIN = 4, P_HALT = 5;
    localparam int DRAIN_LEN = 4;
    int     ph;
    int     drain_left;
    longint mcyc;
    bit     mprev;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          er, ef, eh, rise;
        logic [31:0] en;
        longint      ecs;
        er = rst && (ph == P_CONT || ph == P_EXEC || ph == P_DRAIN);
        eh = rst && (ph == P_HALT);
        ef = 1'b0;
        if (!rst)        en = 32'h0;
        else if (!er)    en = pc;
        else if (branch) begin en = bt; ef = 1'b1; end
        else if (jump)   begin en = jt; ef = 1'b1; end
        else if (stall)  en = pc;
        else             en = pc + 32'd4;
        ecs = (mcyc > 15) ? 15 : mcyc;
        chk("next_pc", {32'h0, next_pc}, {32'h0, en});
        chk("run",     {63'h0, run},     {63'h0, er});
        chk("flush",   {63'h0, flush},   {63'h0, ef});
        chk("halted",  {63'h0, halted},  {63'h0, eh});
        chk("cycles",  {32'h0, cycles},  mcyc);
        chk("small_next_pc", {32'h0, s_next_pc}, {32'h0, en});
        chk("small_run",     {63'h0, s_run},     {63'h0, er});
        chk("small_cycles",  {60'h0, s_cycles},  ecs);
        if (!rst) begin
            ph = P_IDLE; mcyc = 0; mprev = 1'b0; drain_left = 0;
        end else begin
            if (er && mcyc < 64'hFFFF_FFFF) mcyc++;
            rise = step && !mprev;
            case (ph)
                P_IDLE:  if (start) ph = mode ? P_WAIT : P_CONT;
                P_CONT:  if (halt) begin ph = P_DRAIN; drain_left = DRAIN_LEN; end
                P_WAIT:  if (rise) ph = P_EXEC;
                P_EXEC:  if (halt) begin ph = P_DRAIN; drain_left = DRAIN_LEN; end
                         else ph = P_WAIT;
                P_DRAIN: begin drain_left--; if (drain_left == 0) ph = P_HALT; end
                default: ;
            endcase
            mprev = step;
        end
    endtask

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        rst = v.rst; start = v.start; mode = v.mode; step = v.step;
        jump = v.jump; branch = v.branch; stall = v.stall; halt = v.halt;
        pc = v.pc; jt = v.jt; bt = v.bt;
        #2;
        model_step();
    endtask

    function automatic vec_t quiet();
        vec_t v;
        v = '{default: '0};
        v.rst = 1'b1;
        v.pc  = 32'h1000;
        return v;
    endfunction

    function automatic vec_t row(logic st, logic [31:0] p, logic br, logic [31:0] b,
                                 logic jp, logic [31:0] j, logic sl, logic [31:0] en,
                                 logic er, logic ef, logic [31:0] ec);
        vec_t v;
        v = quiet();
        v.start = st; v.pc = p; v.branch = br; v.bt = b; v.jump = jp; v.jt = j;
        v.stall = sl; v.e_next = en; v.e_run = er; v.e_flush = ef; v.e_cycles = ec;
        return v;
    endfunction

    task automatic do_reset();
        vec_t v;
        v = quiet();
        v.rst = 1'b0;
        repeat (2) drive(v);
    endtask

    vec_t tbl[9];
    vec_t v;
    int   nrun;

    initial begin
        rst = 1'b0; start = 0; mode = 0; step = 0; jump = 0; branch = 0; stall = 0; halt = 0;
        pc = 0; jt = 0; bt = 0;
        repeat (2) @(negedge clk);
        ph = P_IDLE; mcyc = 0; mprev = 1'b0; drain_left = 0;

        tbl[0] = row(1, 32'h100,        0, 0,      0, 0,      0, 32'h100, 0, 0, 0);
        tbl[1] = row(0, 32'h100,        0, 0,      0, 0,      0, 32'h104, 1, 0, 0);
        tbl[2] = row(0, 32'h104,        0, 0,      0, 0,      0, 32'h108, 1, 0, 1);
        tbl[3] = row(0, 32'h108,        0, 0,      0, 0,      0, 32'h10C, 1, 0, 2);
        tbl[4] = row(0, 32'h10C,        1, 32'h200, 0, 0,     1, 32'h200, 1, 1, 3);
        tbl[5] = row(0, 32'h200,        0, 0,      0, 0,      1, 32'h200, 1, 0, 4);
        tbl[6] = row(0, 32'h200,        0, 0,      1, 32'h300, 0, 32'h300, 1, 1, 5);
        tbl[7] = row(0, 32'h300,        1, 32'h500, 1, 32'h400, 0, 32'h500, 1, 1, 6);
        tbl[8] = row(0, 32'hFFFF_FFFC,  0, 0,      0, 0,      0, 32'h0,   1, 0, 7);

        // Directed table: start, sequential, redirects, stall, wrap-around.
        do_reset();
        chk("reset_cycles", {32'h0, cycles}, 64'h0);
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i]);
            chk($sformatf("tbl%0d_next", i),   {32'h0, next_pc}, {32'h0, tbl[i].e_next});
            chk($sformatf("tbl%0d_run", i),    {63'h0, run},     {63'h0, tbl[i].e_run});
            chk($sformatf("tbl%0d_flush", i),  {63'h0, flush},   {63'h0, tbl[i].e_flush});
            chk($sformatf("tbl%0d_cycles", i), {32'h0, cycles},  {32'h0, tbl[i].e_cycles});
        end

        // HALT in RUN: four drain cycles (redirect honoured, repeat HALT ignored), then frozen.
        v = quiet(); v.halt = 1'b1; v.pc = 32'h20;
        drive(v);
        nrun = 0;
        for (int i = 0; i < 6; i++) begin
            v = quiet(); v.pc = 32'h24 + 32'(4 * i);
            if (i == 1) begin v.branch = 1'b1; v.bt = 32'h800; end
            if (i == 2) v.halt = 1'b1;
            drive(v);
            nrun += int'(run);
        end
        chk("drain_run_count", 64'(nrun), 64'd4);
        chk("halted_after_drain", {63'h0, halted}, 64'h1);
        v = quiet(); v.start = 1'b1; v.step = 1'b1;
        repeat (2) drive(v);
        chk("halted_ignores_start", {63'h0, halted}, 64'h1);
        chk("halted_no_run", {63'h0, run}, 64'h0);

        // Step mode: held step gives one step; stall inside a step holds PC.
        do_reset();
        v = quiet(); v.start = 1'b1; v.mode = 1'b1;
        drive(v);
        nrun = 0;
        for (int i = 0; i < 5; i++) begin
            v = quiet(); v.step = 1'b1; v.pc = 32'h40;
            drive(v);
            nrun += int'(run);
        end
        chk("step_run_count", 64'(nrun), 64'd1);
        v = quiet(); v.pc = 32'h40;
        drive(v);
        chk("step_cycles", {32'h0, cycles}, 64'd1);
        v.step = 1'b1;
        drive(v);
        v.stall = 1'b1;
        drive(v);
        chk("step_stall_run", {63'h0, run}, 64'h1);
        chk("step_stall_pc", {32'h0, next_pc}, 64'h40);
        v = quiet(); drive(v);
        v.step = 1'b1; drive(v);
        v.halt = 1'b1; drive(v);
        nrun = 0;
        for (int i = 0; i < 6; i++) begin
            v = quiet(); drive(v);
            nrun += int'(run);
        end
        chk("step_drain_run_count", 64'(nrun), 64'd4);
        chk("step_halted", {63'h0, halted}, 64'h1);

        // Reset in the middle of DRAIN.
        do_reset();
        v = quiet(); v.start = 1'b1; drive(v);
        v = quiet(); v.halt = 1'b1; drive(v);
        v = quiet(); repeat (2) drive(v);
        v.rst = 1'b0; v.pc = 32'h1234;
        drive(v);
        chk("rst_next_pc", {32'h0, next_pc}, 64'h0);
        chk("rst_run", {63'h0, run}, 64'h0);
        v.rst = 1'b1;
        drive(v);
        chk("rst_idle_cycles", {32'h0, cycles}, 64'h0);
        chk("rst_idle_run", {63'h0, run}, 64'h0);
        chk("rst_idle_pc", {32'h0, next_pc}, 64'h1234);

        // Counter saturation on the 4-bit copy.
        do_reset();
        v = quiet(); v.start = 1'b1; drive(v);
        v = quiet();
        repeat (21) drive(v);
        chk("sat_small", {60'h0, s_cycles}, 64'hF);
        chk("sat_wide", {32'h0, cycles}, 64'd20);

        // Randomized run against the model.
        v = quiet();
        for (int i = 0; i < 1500; i++) begin
            v.rst    = ($urandom_range(0, 59) != 0);
            v.start  = ($urandom_range(0, 7) == 0);
            v.mode   = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 2) == 0) v.step = ~v.step;
            v.pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            v.jump   = ($urandom_range(0, 7) == 0);
            v.jt     = $urandom;
            v.branch = ($urandom_range(0, 7) == 0);
            v.bt     = $urandom;
            v.stall  = ($urandom_range(0, 5) == 0);
            v.halt   = ($urandom_range(0, 29) == 0);
            drive(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
